// File: rtl/ram_data_arbiter.sv
// rtl/ram_data_arbiter.sv - two-requester round-robin arbiter for the RAM_data simple-dual-port RAM
// Optional read-after-write forwarding is enabled by defining RAM_ARB_FWD_EN.
module ram_data_arbiter #(
    parameter int ADDR_W     = 17,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] ram_rdaddress,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    localparam logic OWN_A = 1'b0;
    localparam logic OWN_B = 1'b1;

    logic a_rd_cand, b_rd_cand, a_wr_cand, b_wr_cand;
    logic a_rd_gnt, b_rd_gnt, a_wr_gnt, b_wr_gnt;
    logic rd_gnt, wr_gnt;
    logic rd_last_q, rd_last_d;
    logic wr_last_q, wr_last_d;
    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
    logic [RD_LATENCY-1:0] tag_own_q, tag_own_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
    logic [DATA_W-1:0] b_rdata_q, b_rdata_d;
    logic [DATA_W-1:0] ret_data;
    logic tail_vld, tail_own;

    // Gating candidates with reset_n keeps every grant and RAM strobe low while in reset.
    assign a_rd_cand = reset_n & a_req & ~a_we;
    assign b_rd_cand = reset_n & b_req & ~b_we;
    assign a_wr_cand = reset_n & a_req & a_we;
    assign b_wr_cand = reset_n & b_req & b_we;

    assign a_rd_gnt = a_rd_cand & (~b_rd_cand | (rd_last_q == OWN_B));
    assign b_rd_gnt = b_rd_cand & (~a_rd_cand | (rd_last_q == OWN_A));
    assign a_wr_gnt = a_wr_cand & (~b_wr_cand | (wr_last_q == OWN_B));
    assign b_wr_gnt = b_wr_cand & (~a_wr_cand | (wr_last_q == OWN_A));

    assign rd_gnt = a_rd_gnt | b_rd_gnt;
    assign wr_gnt = a_wr_gnt | b_wr_gnt;
    assign a_gnt  = a_rd_gnt | a_wr_gnt;
    assign b_gnt  = b_rd_gnt | b_wr_gnt;

    assign rd_last_d = rd_gnt ? (b_rd_gnt ? OWN_B : OWN_A) : rd_last_q;
    assign wr_last_d = wr_gnt ? (b_wr_gnt ? OWN_B : OWN_A) : wr_last_q;

    assign ram_rdaddress = a_rd_gnt ? a_addr  : (b_rd_gnt ? b_addr  : '0);
    assign ram_wraddress = a_wr_gnt ? a_addr  : (b_wr_gnt ? b_addr  : '0);
    assign ram_data      = a_wr_gnt ? a_wdata : (b_wr_gnt ? b_wdata : '0);
    assign ram_wren      = wr_gnt;

    // Stage 0 is loaded by the grant; the tail lines up with RAM_data q.
    always_comb begin
        tag_vld_d    = '0;
        tag_own_d    = '0;
        tag_vld_d[0] = rd_gnt;
        tag_own_d[0] = b_rd_gnt;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i] = tag_vld_q[i-1];
            tag_own_d[i] = tag_own_q[i-1];
        end
    end

    assign tail_vld = tag_vld_q[RD_LATENCY-1];
    assign tail_own = tag_own_q[RD_LATENCY-1];

`ifdef RAM_ARB_FWD_EN
    logic [RD_LATENCY-1:0] tag_hit_q, tag_hit_d;
    logic [DATA_W-1:0]     tag_wd_q [RD_LATENCY];
    logic [DATA_W-1:0]     tag_wd_d [RD_LATENCY];

    always_comb begin
        tag_hit_d    = '0;
        tag_hit_d[0] = rd_gnt & wr_gnt & (ram_rdaddress == ram_wraddress);
        tag_wd_d[0]  = ram_data;
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_hit_d[i] = tag_hit_q[i-1];
            tag_wd_d[i]  = tag_wd_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_hit_q <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_wd_q[i] <= '0;
            end
        end else begin
            tag_hit_q <= tag_hit_d;
            for (int i = 0; i < RD_LATENCY; i++) begin
                tag_wd_q[i] <= tag_wd_d[i];
            end
        end
    end

    assign ret_data = tag_hit_q[RD_LATENCY-1] ? tag_wd_q[RD_LATENCY-1] : ram_q;
`else
    assign ret_data = ram_q;
`endif

    assign a_rvalid  = tail_vld & (tail_own == OWN_A);
    assign b_rvalid  = tail_vld & (tail_own == OWN_B);
    assign a_rdata   = a_rvalid ? ret_data : a_rdata_q;
    assign b_rdata   = b_rvalid ? ret_data : b_rdata_q;
    assign a_rdata_d = a_rdata;
    assign b_rdata_d = b_rdata;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_last_q <= OWN_B;
            wr_last_q <= OWN_B;
            tag_vld_q <= '0;
            tag_own_q <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            rd_last_q <= rd_last_d;
            wr_last_q <= wr_last_d;
            tag_vld_q <= tag_vld_d;
            tag_own_q <= tag_own_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

endmodule

// File: tb/tb_ram_data_arbiter.sv
// tb/tb_ram_data_arbiter.sv - randomized bench for ram_data_arbiter with a behavioural reference model
module tb_ram_data_arbiter;
    localparam int AW  = 17;
    localparam int DW  = 32;
    localparam int LAT = 2;
`ifdef RAM_ARB_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          a_req = 1'b0, a_we = 1'b0;
    logic [AW-1:0] a_addr = '0;
    logic [DW-1:0] a_wdata = '0;
    logic          b_req = 1'b0, b_we = 1'b0;
    logic [AW-1:0] b_addr = '0;
    logic [DW-1:0] b_wdata = '0;
    logic          a_gnt, a_rvalid, b_gnt, b_rvalid, ram_wren;
    logic [DW-1:0] a_rdata, b_rdata, ram_data, ram_q;
    logic [AW-1:0] ram_rdaddress, ram_wraddress;

    always #5 clock = ~clock;

    ram_data_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_rdaddress(ram_rdaddress), .ram_wraddress(ram_wraddress),
        .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q)
    );

    // RAM_data stand-in: LAT-cycle registered read, old data on same-address collision.
    bit [DW-1:0] ram_mem [16];
    bit [DW-1:0] rp [LAT];
    always @(posedge clock) begin
        for (int i = LAT - 1; i > 0; i--) rp[i] <= rp[i-1];
        rp[0] <= ram_mem[ram_rdaddress[3:0]];
        if (ram_wren) ram_mem[ram_wraddress[3:0]] <= ram_data;
    end
    assign ram_q = rp[LAT-1];

    typedef struct {
        int          due;
        bit          own;
        bit [DW-1:0] data;
    } ev_t;

    ev_t         evq[$];
    bit [DW-1:0] ref_mem [16];
    int          now, rd_last, wr_last, a_wait, b_wait;
    bit [DW-1:0] a_hold, b_hold;
    int          n_cmp, n_bad;
    bit          e_a_gnt, e_b_gnt;
    logic          s_a_gnt, s_b_gnt, s_a_rv, s_b_rv, s_wren;
    logic [DW-1:0] s_a_rdata, s_b_rdata, s_wdata;
    logic [AW-1:0] s_rdaddr, s_wraddr;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, now);
        end
    endtask

    task automatic set_a(input bit req, input bit we, input int addr, input bit [DW-1:0] wd);
        a_req = req; a_we = we; a_addr = AW'(addr); a_wdata = wd;
    endtask

    task automatic set_b(input bit req, input bit we, input int addr, input bit [DW-1:0] wd);
        b_req = req; b_we = we; b_addr = AW'(addr); b_wdata = wd;
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, step to posedge+1.
    task automatic cycle();
        bit ar, br, aw, bw, agr, bgr, agw, bgw, e_arv, e_brv;
        bit [AW-1:0] e_rda, e_wra;
        bit [DW-1:0] e_wd, e_ard, e_brd, rd_val;
        ev_t ev;
        #3;
        s_a_gnt = a_gnt; s_b_gnt = b_gnt; s_a_rv = a_rvalid; s_b_rv = b_rvalid;
        s_a_rdata = a_rdata; s_b_rdata = b_rdata; s_wren = ram_wren;
        s_wdata = ram_data; s_rdaddr = ram_rdaddress; s_wraddr = ram_wraddress;
        if (!reset_n) begin
            evq.delete();
            rd_last = 1; wr_last = 1;
            a_hold = '0; b_hold = '0;
            a_wait = 0; b_wait = 0;
        end
        ar = reset_n && a_req && !a_we;  br = reset_n && b_req && !b_we;
        aw = reset_n && a_req && a_we;   bw = reset_n && b_req && b_we;
        agr = ar && (!br || rd_last == 1);  bgr = br && !agr;
        agw = aw && (!bw || wr_last == 1);  bgw = bw && !agw;
        e_rda = agr ? a_addr : (bgr ? b_addr : '0);
        e_wra = agw ? a_addr : (bgw ? b_addr : '0);
        e_wd  = agw ? a_wdata : (bgw ? b_wdata : '0);
        e_arv = 1'b0; e_brv = 1'b0; e_ard = a_hold; e_brd = b_hold;
        foreach (evq[i]) begin
            if (evq[i].due == now) begin
                if (evq[i].own) begin e_brv = 1'b1; e_brd = evq[i].data; end
                else            begin e_arv = 1'b1; e_ard = evq[i].data; end
            end
        end
        chk("a_gnt", s_a_gnt, agr | agw);
        chk("b_gnt", s_b_gnt, bgr | bgw);
        chk("ram_wren", s_wren, agw | bgw);
        chk("ram_rdaddress", s_rdaddr, e_rda);
        chk("ram_wraddress", s_wraddr, e_wra);
        chk("ram_data", s_wdata, e_wd);
        chk("a_rvalid", s_a_rv, e_arv);
        chk("b_rvalid", s_b_rv, e_brv);
        chk("a_rdata", s_a_rdata, e_ard);
        chk("b_rdata", s_b_rdata, e_brd);
        if (reset_n && a_req) begin
            a_wait = s_a_gnt ? 0 : a_wait + 1;
            chk("a_starvation", a_wait <= 1, 1);
        end
        if (reset_n && b_req) begin
            b_wait = s_b_gnt ? 0 : b_wait + 1;
            chk("b_starvation", b_wait <= 1, 1);
        end
        if (reset_n) begin
            if (e_arv) a_hold = e_ard;
            if (e_brv) b_hold = e_brd;
            while (evq.size() > 0 && evq[0].due <= now) void'(evq.pop_front());
            if (agr || bgr) begin
                rd_val = ref_mem[e_rda[3:0]];
                if (FWD && (agw || bgw) && e_wra == e_rda) rd_val = e_wd;
                ev.due = now + LAT; ev.own = bgr; ev.data = rd_val;
                evq.push_back(ev);
                rd_last = bgr ? 1 : 0;
            end
            if (agw || bgw) begin
                ref_mem[e_wra[3:0]] = e_wd;
                wr_last = bgw ? 1 : 0;
            end
        end
        e_a_gnt = agr | agw;
        e_b_gnt = bgr | bgw;
        @(posedge clock);
        now++;
        #1;
    endtask

    task automatic idle(input int n);
        set_a(0, 0, 0, '0); set_b(0, 0, 0, '0);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        n_cmp = 0; n_bad = 0; now = 0;
        rd_last = 1; wr_last = 1; a_hold = '0; b_hold = '0; a_wait = 0; b_wait = 0;
        reset_n = 1'b0;
        set_a(1, 0, 0, '0); set_b(1, 0, 4, '0);
        @(posedge clock); #1;

        // reset holds everything quiet, then A wins first
        cycle();
        chk("t1_rst_a_gnt", s_a_gnt, 0);
        chk("t1_rst_b_gnt", s_b_gnt, 0);
        chk("t1_rst_wren", s_wren, 0);
        chk("t1_rst_rvalid", s_a_rv | s_b_rv, 0);
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("t1_a_first", s_a_gnt, 1);
        chk("t1_b_waits", s_b_gnt, 0);
        set_a(0, 0, 0, '0);
        cycle();
        chk("t1_b_next", s_b_gnt, 1);
        idle(LAT + 2);

        // write then read back with fixed latency
        set_a(1, 1, 0, 32'hA5A5A5A5);
        cycle();
        chk("t2_wr_gnt", s_a_gnt, 1);
        chk("t2_wren", s_wren, 1);
        set_a(1, 0, 0, '0);
        cycle();
        chk("t2_rd_gnt", s_a_gnt, 1);
        set_a(0, 0, 0, '0);
        for (int k = 1; k <= LAT; k++) begin
            cycle();
            chk("t2_rvalid_timing", s_a_rv, k == LAT);
        end
        chk("t2_rdata", s_a_rdata, 32'hA5A5A5A5);
        idle(2);

        // concurrent read (A) and write (B)
        set_a(1, 0, 1, '0); set_b(1, 1, 2, 32'hA);
        cycle();
        chk("t3_a_gnt", s_a_gnt, 1);
        chk("t3_b_gnt", s_b_gnt, 1);
        chk("t3_wren", s_wren, 1);
        chk("t3_wraddr", s_wraddr, 2);
        chk("t3_rdaddr", s_rdaddr, 1);
        idle(LAT + 1);

        // B read alone leaves rd_last at B, then contention alternates A,B,A,B
        set_b(1, 0, 9, '0);
        cycle();
        set_a(1, 0, 3, '0); set_b(1, 0, 9, '0);
        for (int k = 0; k < 6; k++) begin
            if (k == 4) begin set_a(0, 0, 0, '0); set_b(0, 0, 0, '0); end
            cycle();
            if (k < 4) begin
                chk("t4_a_gnt", s_a_gnt, k % 2 == 0);
                chk("t4_b_gnt", s_b_gnt, k % 2 == 1);
            end
            if (k >= LAT) begin
                chk("t4_a_rvalid", s_a_rv, (k - LAT) % 2 == 0);
                chk("t4_b_rvalid", s_b_rv, (k - LAT) % 2 == 1);
            end
        end
        idle(2);

        // same-address read/write collision
        set_a(1, 1, 5, 32'h5555);
        cycle();
        set_a(1, 0, 5, '0); set_b(1, 1, 5, 32'h1234);
        cycle();
        chk("t5_a_gnt", s_a_gnt, 1);
        chk("t5_b_gnt", s_b_gnt, 1);
        set_a(0, 0, 0, '0); set_b(0, 0, 0, '0);
        for (int k = 1; k <= LAT; k++) cycle();
        chk("t5_rvalid", s_a_rv, 1);
        chk("t5_rdata", s_a_rdata, FWD ? 32'h1234 : 32'h5555);
        idle(2);

        // reset one cycle after a read grant drops the read
        set_a(1, 0, 0, '0);
        cycle();
        chk("t6_rd_gnt", s_a_gnt, 1);
        set_a(0, 0, 0, '0);
        reset_n = 1'b0;
        cycle();
        chk("t6_rst_rvalid", s_a_rv, 0);
        chk("t6_rst_rdata", s_a_rdata, 0);
        reset_n = 1'b1;
        for (int k = 0; k < LAT + 1; k++) begin
            cycle();
            chk("t6_no_rvalid", s_a_rv | s_b_rv, 0);
        end

        // randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            if (e_a_gnt || !a_req) begin
                if ($urandom_range(3) != 0) set_a(1, 1'($urandom_range(1)), $urandom_range(15), $urandom);
                else set_a(0, 0, 0, '0);
            end
            if (e_b_gnt || !b_req) begin
                if ($urandom_range(3) != 0) set_b(1, 1'($urandom_range(1)), $urandom_range(15), $urandom);
                else set_b(0, 0, 0, '0);
            end
            reset_n = ($urandom_range(299) != 0);
            cycle();
        end
        reset_n = 1'b1;
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
